// File: rtl/pwm_freq_meter_pkg.sv
// Shared definitions for the PWM frequency meter: FSM state encoding and parameter defaults.
package pwm_freq_meter_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARM  = 3'd1,
      MEAS = 3'd2,
      DIV  = 3'd3,
      DUTY = 3'd4,
      DONE = 3'd5
   } state_e;

   localparam int unsigned SOURCE_CLK_DEF = 25_000_000;
   localparam int unsigned PERIOD_W_DEF   = 26;
   localparam int unsigned FREQ_W_DEF     = 11;
   localparam int unsigned TIMEOUT_DEF    = 25_000_000;

endpackage

// File: rtl/pwm_freq_meter_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; start reloads, done pulses once.
module seq_divider #(
   parameter int unsigned W = 26
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quotient,
   output logic         done
);
   localparam int unsigned CW = $clog2(W + 1);

   logic [W-1:0]  rem_q, rem_d, quo_q, quo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d, done_q, done_d;
   logic [W:0]    shifted, diff;

   always_comb begin
      shifted = {rem_q, quo_q[W-1]};
      diff    = shifted - {1'b0, divisor};
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      done_d  = 1'b0;
      if (start) begin
         rem_d = '0;
         quo_d = dividend;
         cnt_d = CW'(W);
         run_d = 1'b1;
      end else if (run_q) begin
         // Bit W of the difference is the borrow: set means the trial subtraction failed.
         if (!diff[W]) begin
            rem_d = diff[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b1};
         end else begin
            rem_d = shifted[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
         end
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign quotient = quo_q;
   assign done     = done_q;

endmodule

// File: rtl/pwm_freq_meter.sv
// Measures period, high time and frequency of pwm_in against sys_clk.
// Define DUTY_CALC_EN to build the duty-cycle stage (reuses the divider); otherwise duty is 0.
module pwm_freq_meter
   import pwm_freq_meter_pkg::*;
#(
   parameter int unsigned SOURCE_CLK = SOURCE_CLK_DEF,
   parameter int unsigned PERIOD_W   = PERIOD_W_DEF,
   parameter int unsigned FREQ_W     = FREQ_W_DEF,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                pwm_in,
   input  logic                meas_en,
   output logic [PERIOD_W-1:0] period,
   output logic [PERIOD_W-1:0] pulse,
   output logic [FREQ_W-1:0]   freq,
   output logic [6:0]          duty,
   output logic                valid,
   output logic                ovf,
   output logic                timeout,
   output logic                busy
);
`ifdef DUTY_CALC_EN
   localparam int unsigned DIV_W = PERIOD_W + 7;
`else
   localparam int unsigned DIV_W = PERIOD_W;
`endif
   localparam logic [DIV_W-1:0]    SRC = DIV_W'(SOURCE_CLK);
   localparam logic [PERIOD_W-1:0] TMO = PERIOD_W'(TIMEOUT);

   state_e              state_q, state_d;
   logic                sync1_q, sync1_d, sync2_q, sync2_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d, hi_q, hi_d;
   logic [PERIOD_W-1:0] period_r_q, period_r_d, pulse_r_q, pulse_r_d;
   logic                start_q, start_d;
   logic [PERIOD_W-1:0] period_q, period_d, pulse_q, pulse_d;
   logic [FREQ_W-1:0]   freq_q, freq_d;
   logic                valid_q, valid_d, ovf_q, ovf_d, timeout_q, timeout_d, busy_q, busy_d;
   logic                rise, fin, tmo, fovf, div_done;
   logic [FREQ_W-1:0]   fq;
   logic [DIV_W-1:0]    div_a, div_q;
`ifdef DUTY_CALC_EN
   logic [FREQ_W-1:0]   freq_r_q, freq_r_d;
   logic                ovf_r_q, ovf_r_d;
   logic [6:0]          duty_q, duty_d, dq;
   logic [DIV_W-1:0]    prod;

   assign prod  = DIV_W'(pulse_r_q) * DIV_W'(100);
   assign dq    = (div_q > DIV_W'(100)) ? 7'd100 : div_q[6:0];
   assign div_a = (state_q == DUTY) ? prod : SRC;
`else
   assign div_a = SRC;
`endif

   assign fovf = |div_q[DIV_W-1:FREQ_W];
   assign fq   = fovf ? '1 : div_q[FREQ_W-1:0];

   seq_divider #(.W(DIV_W)) u_div (
      .clk      (sys_clk),
      .rst      (sys_rst),
      .start    (start_q),
      .dividend (div_a),
      .divisor  (DIV_W'(period_r_q)),
      .quotient (div_q),
      .done     (div_done)
   );

   always_comb begin
      sync1_d    = pwm_in;
      sync2_d    = sync1_q;
      rise       = sync1_q & ~sync2_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      period_r_d = period_r_q;
      pulse_r_d  = pulse_r_q;
      start_d    = 1'b0;
      period_d   = period_q;
      pulse_d    = pulse_q;
      freq_d     = freq_q;
      ovf_d      = ovf_q;
      timeout_d  = timeout_q;
      valid_d    = 1'b0;
      fin        = 1'b0;
      tmo        = 1'b0;
`ifdef DUTY_CALC_EN
      freq_r_d   = freq_r_q;
      ovf_r_d    = ovf_r_q;
      duty_d     = duty_q;
`endif
      case (state_q)
         IDLE: if (meas_en) begin
            state_d = ARM;
            cnt_d   = '0;
         end
         ARM: begin
            if (!meas_en)          state_d = IDLE;
            else if (rise) begin
               state_d = MEAS;
               cnt_d   = PERIOD_W'(1);
               hi_d    = PERIOD_W'(1);
            end
            else if (cnt_q == TMO) tmo = 1'b1;
            else                   cnt_d = cnt_q + 1'b1;
         end
         MEAS: begin
            if (!meas_en) state_d = IDLE;
            else if (rise) begin
               period_r_d = cnt_q;
               pulse_r_d  = hi_q;
               start_d    = 1'b1;
               state_d    = DIV;
            end
            else if (cnt_q == TMO) tmo = 1'b1;
            else begin
               cnt_d = cnt_q + 1'b1;
               hi_d  = hi_q + PERIOD_W'(sync1_q);
            end
         end
         DIV: begin
            if (!meas_en) state_d = IDLE;
            else if (div_done) begin
`ifdef DUTY_CALC_EN
               freq_r_d = fq;
               ovf_r_d  = fovf;
               start_d  = 1'b1;
               state_d  = DUTY;
`else
               fin = 1'b1;
`endif
            end
         end
`ifdef DUTY_CALC_EN
         DUTY: begin
            if (!meas_en) state_d = IDLE;
            else if (div_done) begin
               duty_d = dq;
               fin    = 1'b1;
            end
         end
`endif
         DONE: begin
            state_d = meas_en ? ARM : IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
      if (fin) begin
         period_d  = period_r_q;
         pulse_d   = pulse_r_q;
`ifdef DUTY_CALC_EN
         freq_d    = freq_r_q;
         ovf_d     = ovf_r_q;
`else
         freq_d    = fq;
         ovf_d     = fovf;
`endif
         timeout_d = 1'b0;
         valid_d   = 1'b1;
         state_d   = DONE;
      end
      if (tmo) begin
         period_d  = '0;
         pulse_d   = '0;
         freq_d    = '0;
         ovf_d     = 1'b0;
         timeout_d = 1'b1;
`ifdef DUTY_CALC_EN
         duty_d    = '0;
`endif
         valid_d   = 1'b1;
         state_d   = DONE;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= IDLE;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         cnt_q      <= '0;
         hi_q       <= '0;
         period_r_q <= '0;
         pulse_r_q  <= '0;
         start_q    <= 1'b0;
         period_q   <= '0;
         pulse_q    <= '0;
         freq_q     <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         timeout_q  <= 1'b0;
         busy_q     <= 1'b0;
`ifdef DUTY_CALC_EN
         freq_r_q   <= '0;
         ovf_r_q    <= 1'b0;
         duty_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         period_r_q <= period_r_d;
         pulse_r_q  <= pulse_r_d;
         start_q    <= start_d;
         period_q   <= period_d;
         pulse_q    <= pulse_d;
         freq_q     <= freq_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
         timeout_q  <= timeout_d;
         busy_q     <= busy_d;
`ifdef DUTY_CALC_EN
         freq_r_q   <= freq_r_d;
         ovf_r_q    <= ovf_r_d;
         duty_q     <= duty_d;
`endif
      end
   end

   assign period  = period_q;
   assign pulse   = pulse_q;
   assign freq    = freq_q;
   assign valid   = valid_q;
   assign ovf     = ovf_q;
   assign timeout = timeout_q;
   assign busy    = busy_q;
`ifdef DUTY_CALC_EN
   assign duty    = duty_q;
`else
   assign duty    = '0;
`endif

endmodule

// File: tb/tb_pwm_freq_meter.sv
// Self-checking bench for pwm_freq_meter with a scaled-down clock and timeout.
module tb_pwm_freq_meter;
   localparam int unsigned SRC = 250_000;
   localparam int unsigned PW  = 26;
   localparam int unsigned FW  = 11;
   localparam int unsigned TMO = 1000;
`ifdef DUTY_CALC_EN
   localparam bit DUTY_ON = 1'b1;
`else
   localparam bit DUTY_ON = 1'b0;
`endif

   typedef struct packed {
      logic [PW-1:0] period;
      logic [PW-1:0] pulse;
      logic [FW-1:0] freq;
      logic [6:0]    duty;
      logic          ovf;
      logic          timeout;
   } res_t;

   typedef struct {
      int unsigned p;
      int unsigned h;
      res_t        lit;
   } vec_t;

   logic clk = 1'b0, sys_rst = 1'b1, pwm_in = 1'b0, meas_en = 1'b0;
   logic [PW-1:0] period, pulse;
   logic [FW-1:0] freq;
   logic [6:0]    duty;
   logic          valid, ovf, timeout, busy;
   res_t          dut_r;

   int   checks = 0, errors = 0;
   res_t exp_r = '0, held_r = '0;
   bit   allow_valid = 1'b1;
   int unsigned gen_p = 0, gen_h = 0, phase = 0;
   bit   gen_lvl = 1'b0;

   always #5 clk = ~clk;

   pwm_freq_meter #(
      .SOURCE_CLK (SRC),
      .PERIOD_W   (PW),
      .FREQ_W     (FW),
      .TIMEOUT    (TMO)
   ) dut (
      .sys_clk (clk),
      .sys_rst (sys_rst),
      .pwm_in  (pwm_in),
      .meas_en (meas_en),
      .period  (period),
      .pulse   (pulse),
      .freq    (freq),
      .duty    (duty),
      .valid   (valid),
      .ovf     (ovf),
      .timeout (timeout),
      .busy    (busy)
   );

   always_comb dut_r = {period, pulse, freq, duty, ovf, timeout};

   // Clock-synchronous waveform source: high for gen_h of every gen_p cycles.
   always @(negedge clk) begin
      if (gen_p == 0) pwm_in = gen_lvl;
      else begin
         pwm_in = ((phase % gen_p) < gen_h);
         phase  = (phase + 1) % gen_p;
      end
   end

   function automatic res_t mk(int unsigned p, int unsigned h, int unsigned f,
                               int unsigned d, bit o, bit t);
      res_t r;
      r.period  = PW'(p);
      r.pulse   = PW'(h);
      r.freq    = FW'(f);
      r.duty    = DUTY_ON ? 7'(d) : 7'd0;
      r.ovf     = o;
      r.timeout = t;
      return r;
   endfunction

   // What a measurement of a steady p/h waveform must report; p==0 means a constant level.
   function automatic res_t model(int unsigned p, int unsigned h);
      int unsigned q, d;
      if (p == 0 || p > TMO) return mk(0, 0, 0, 0, 1'b0, 1'b1);
      q = SRC / p;
      d = (h * 100) / p;
      if (d > 100) d = 100;
      if (q > 2047) return mk(p, h, 2047, d, 1'b1, 1'b0);
      return mk(p, h, q, d, 1'b0, 1'b0);
   endfunction

   always @(posedge clk) begin
      #1;
      checks++;
      if (valid === 1'b1) begin
         if (!allow_valid) begin
            errors++;
            $display("FAIL unexpected_valid got valid=1 required valid=0 at %0t", $time);
         end else if (dut_r !== exp_r) begin
            errors++;
            $display("FAIL model_result got %h required %h at %0t", dut_r, exp_r, $time);
         end
         held_r = exp_r;
      end else if (dut_r !== held_r) begin
         errors++;
         $display("FAIL held_result got %h required %h at %0t", dut_r, held_r, $time);
      end
   end

   task automatic chk(input string name, input res_t got, input res_t want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h required %h", name, got, want);
      end
   endtask

   task automatic chk_bit(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %b required %b", name, got, want);
      end
   endtask

   task automatic wait_valid(input string name, input int unsigned max, output int unsigned n);
      bit found;
      n = 0;
      found = 1'b0;
      while (n < max && !found) begin
         @(posedge clk);
         #1;
         n++;
         if (valid === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s no valid within %0d cycles required one", name, max);
      end
   endtask

   task automatic setup(input int unsigned p, input int unsigned h, input bit lvl);
      @(negedge clk);
      meas_en     = 1'b0;
      allow_valid = 1'b1;
      gen_p       = p;
      gen_h       = h;
      gen_lvl     = lvl;
      exp_r       = model(p, h);
      repeat (5) @(negedge clk);
      meas_en = 1'b1;
   endtask

   vec_t        vecs[5];
   int unsigned n;

   initial begin
      vecs[0] = '{p: 250, h: 50,  lit: mk(250, 50,  1000, 20, 1'b0, 1'b0)};
      vecs[1] = '{p: 568, h: 284, lit: mk(568, 284, 440,  50, 1'b0, 1'b0)};
      vecs[2] = '{p: 50,  h: 10,  lit: mk(50,  10,  2047, 20, 1'b1, 1'b0)};
      vecs[3] = '{p: 122, h: 61,  lit: mk(122, 61,  2047, 50, 1'b1, 1'b0)};
      vecs[4] = '{p: 123, h: 1,   lit: mk(123, 1,   2032, 0,  1'b0, 1'b0)};

      repeat (3) @(negedge clk);
      sys_rst = 1'b0;
      @(posedge clk); #1;
      chk("reset_outputs", dut_r, mk(0, 0, 0, 0, 1'b0, 1'b0));
      chk_bit("reset_busy", busy, 1'b0);
      chk_bit("reset_valid", valid, 1'b0);

      foreach (vecs[i]) begin
         setup(vecs[i].p, vecs[i].h, 1'b0);
         wait_valid("vec_first", 3 * vecs[i].p + 100, n);
         chk($sformatf("vec%0d_first", i), dut_r, vecs[i].lit);
         wait_valid("vec_repeat", 3 * vecs[i].p + 100, n);
         chk($sformatf("vec%0d_repeat", i), dut_r, vecs[i].lit);
      end

      setup(0, 0, 1'b0);
      wait_valid("tmo_low", TMO + 100, n);
      chk("tmo_low_result", dut_r, mk(0, 0, 0, 0, 1'b0, 1'b1));
      checks++;
      if (n < TMO || n > TMO + 10) begin
         errors++;
         $display("FAIL tmo_latency got %0d cycles required %0d..%0d", n, TMO, TMO + 10);
      end
      setup(0, 0, 1'b1);
      wait_valid("tmo_high", TMO + 100, n);
      chk("tmo_high_result", dut_r, mk(0, 0, 0, 0, 1'b0, 1'b1));
      setup(1500, 750, 1'b0);
      wait_valid("tmo_long", 2 * TMO + 100, n);
      chk("tmo_long_result", dut_r, mk(0, 0, 0, 0, 1'b0, 1'b1));

      // Drop meas_en mid-MEAS: results held, busy falls, no strobe.
      setup(250, 125, 1'b0);
      wait_valid("abort_arm", 3 * 250 + 100, n);
      chk("abort_first", dut_r, mk(250, 125, 1000, 50, 1'b0, 1'b0));
      repeat (250) @(negedge clk);
      meas_en     = 1'b0;
      allow_valid = 1'b0;
      @(posedge clk); #1;
      chk_bit("abort_busy", busy, 1'b0);
      repeat (750) @(posedge clk);
      #1;
      chk_bit("abort_busy_late", busy, 1'b0);
      chk("abort_held", dut_r, mk(250, 125, 1000, 50, 1'b0, 1'b0));

      // Reset lands inside the divide of the second measurement after a strobe.
      @(negedge clk);
      allow_valid = 1'b1;
      meas_en     = 1'b1;
      wait_valid("rst_arm", 3 * 250 + 100, n);
      repeat (2 * 250 - 10) @(negedge clk);
      sys_rst     = 1'b1;
      meas_en     = 1'b0;
      allow_valid = 1'b0;
      held_r      = '0;
      @(posedge clk); #1;
      chk("rst_div_outputs", dut_r, mk(0, 0, 0, 0, 1'b0, 1'b0));
      chk_bit("rst_div_busy", busy, 1'b0);
      chk_bit("rst_div_valid", valid, 1'b0);
      @(negedge clk);
      sys_rst = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      chk_bit("rst_div_busy_late", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog simulation did not finish within 200000 cycles");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
